fofb_timeframe_capture: RTL and testbench

- Sits directly downstream of the FOFB communication controller receive path, in the sniffer design clocked by the PCIe user clock.
- Gates received FOFB position packets into timeframes delimited by timeframe_start_i / timeframe_end_i pulses.
- Buffers the gated packets and serialises each one into 64-bit beats on a valid/ready stream feeding the PCIe DMA engine.
- Closes every frame with a trailer word that carries the frame number, the accepted-packet count and the dropped-packet count.

---
 rtl/fofb_sniffer_pkg.sv | 38 +++
 rtl/sniffer_pkt_fifo.sv | 56 +++++
 rtl/fofb_timeframe_capture.sv | 169 ++++++++++++++++
 tb/tb_fofb_timeframe_capture.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fofb_sniffer_pkg.sv
// Shared types and constants for the FOFB timeframe capture path:
// FSM state encoding, packet width and the trailer word layout.
package fofb_sniffer_pkg;

    localparam int PKT_WIDTH = 128;

    localparam logic [7:0] TRAILER_MAGIC = 8'hA5;

    // Trailer word field positions
    localparam int TRL_MAGIC_MSB    = 63;
    localparam int TRL_MAGIC_LSB    = 56;
    localparam int TRL_PKT_CNT_MSB  = 55;
    localparam int TRL_PKT_CNT_LSB  = 40;
    localparam int TRL_DROP_CNT_MSB = 39;
    localparam int TRL_DROP_CNT_LSB = 32;
    localparam int TRL_FRAME_MSB    = 31;
    localparam int TRL_FRAME_LSB    = 0;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CAPTURE,
        ST_FLUSH,
        ST_TRAILER
    } capture_state_t;

    function automatic logic [63:0] make_trailer(input logic [15:0] pkt_cnt,
                                                 input logic [7:0]  drop_cnt,
                                                 input logic [31:0] frame_num);
        logic [63:0] w;
        w = '0;
        w[TRL_MAGIC_MSB:TRL_MAGIC_LSB]       = TRAILER_MAGIC;
        w[TRL_PKT_CNT_MSB:TRL_PKT_CNT_LSB]   = pkt_cnt;
        w[TRL_DROP_CNT_MSB:TRL_DROP_CNT_LSB] = drop_cnt;
        w[TRL_FRAME_MSB:TRL_FRAME_LSB]       = frame_num;
        return w;
    endfunction

endpackage

// File: rtl/sniffer_pkt_fifo.sv
// First-word-fall-through packet FIFO: the head entry is visible on
// rd_data whenever empty is low; rd_en pops it. Also reports fill level.
module sniffer_pkt_fifo #(
    parameter int WIDTH  = 128,
    parameter int AWIDTH = 9
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic              rd_en,
    output logic [WIDTH-1:0]  rd_data,
    output logic              full,
    output logic              empty,
    output logic [AWIDTH:0]   level
);

    localparam logic [AWIDTH:0] DEPTH = {1'b1, {AWIDTH{1'b0}}};

    logic [WIDTH-1:0]  mem [2**AWIDTH];
    logic [AWIDTH-1:0] wr_ptr;
    logic [AWIDTH-1:0] rd_ptr;
    logic [AWIDTH:0]   count;
    logic              do_wr;
    logic              do_rd;

    assign do_wr   = wr_en & ~full;
    assign do_rd   = rd_en & ~empty;
    assign full    = (count == DEPTH);
    assign empty   = (count == '0);
    assign level   = count;
    assign rd_data = mem[rd_ptr];

    // Storage array, written on every accepted push
    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr] <= wr_data;
    end

    // Pointers and occupancy; reset empties the FIFO
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + 1'b1;
            if (do_rd) rd_ptr <= rd_ptr + 1'b1;
            case ({do_wr, do_rd})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/fofb_timeframe_capture.sv
// Gates FOFB packets into timeframes, buffers them and streams each one
// as two 64-bit beats (upper half first) to the DMA, closing every frame
// with a trailer word carrying frame number, accepted and dropped counts.
module fofb_timeframe_capture #(
    parameter int PKT_WIDTH   = fofb_sniffer_pkg::PKT_WIDTH,
    parameter int FIFO_AWIDTH = 9
) (
    input  logic                 sys_clk,
    input  logic                 sys_reset_n,
    input  logic                 timeframe_start_i,
    input  logic                 timeframe_end_i,
    input  logic                 pkt_valid_i,
    input  logic [PKT_WIDTH-1:0] pkt_data_i,
    input  logic                 dma_ready_i,
    output logic                 dma_valid_o,
    output logic [63:0]          dma_data_o,
    output logic                 dma_last_o,
    output logic [31:0]          frame_count_o,
    output logic                 busy_o
);
    import fofb_sniffer_pkg::*;

    localparam int HALF  = PKT_WIDTH / 2;
    localparam int LVL_W = FIFO_AWIDTH + 2;
    localparam logic [LVL_W-1:0] DEPTH = LVL_W'(1) << FIFO_AWIDTH;

    capture_state_t       state;
    logic                 start_pending;
    logic [15:0]          pkt_cnt;
    logic [7:0]           drop_cnt;

    logic                 fifo_wr;
    logic                 fifo_rd;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic [FIFO_AWIDTH:0] fifo_level;
    logic [PKT_WIDTH-1:0] fifo_rd_data;

    logic [PKT_WIDTH-1:0] pkt_p1;
    logic                 vld_p1;
    logic                 phase_p1;

    logic opening, in_window, accept, drop, buf_full;
    logic dma_hs, out_free, ser_idle, flush_done;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    assign dma_hs   = dma_valid_o & dma_ready_i;
    assign out_free = ~dma_valid_o | dma_ready_i;

    // A frame opens from IDLE on a start, or straight out of TRAILER when
    // a start arrived while the previous frame was still closing.
    assign opening  = ((state == ST_IDLE) && (timeframe_start_i || start_pending)) ||
                      ((state == ST_TRAILER) && dma_hs && start_pending);
    assign in_window = (state == ST_CAPTURE) || ((state == ST_IDLE) && opening);

    // The packet held in the serialiser still occupies a buffer slot, so
    // total capacity stays at one FIFO depth.
    assign buf_full = fifo_full || (({1'b0, fifo_level} + LVL_W'(vld_p1)) >= DEPTH);
    assign accept   = pkt_valid_i & in_window;
    assign fifo_wr  = accept & ~buf_full;
    assign drop     = accept & buf_full;

    assign fifo_rd    = ~fifo_empty & (~vld_p1 | (out_free & phase_p1));
    assign ser_idle   = ~vld_p1 & ~dma_valid_o;
    assign flush_done = (state == ST_FLUSH) && fifo_empty && ser_idle;

    sniffer_pkt_fifo #(
        .WIDTH  (PKT_WIDTH),
        .AWIDTH (FIFO_AWIDTH)
    ) u_fifo (
        .clk     (sys_clk),
        .rst_n   (sys_reset_n),
        .wr_en   (fifo_wr),
        .wr_data (pkt_data_i),
        .rd_en   (fifo_rd),
        .rd_data (fifo_rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .level   (fifo_level)
    );

    // Frame FSM with frame/packet/drop counters and registered busy flag
    always_ff @(posedge sys_clk) begin
        if (!sys_reset_n) begin
            state         <= ST_IDLE;
            start_pending <= 1'b0;
            pkt_cnt       <= '0;
            drop_cnt      <= '0;
            frame_count_o <= '0;
            busy_o        <= 1'b0;
        end else if (opening) begin
            state         <= ST_CAPTURE;
            busy_o        <= 1'b1;
            frame_count_o <= frame_count_o + 32'd1;
            pkt_cnt       <= fifo_wr ? 16'd1 : 16'd0;
            drop_cnt      <= '0;
            start_pending <= 1'b0;
        end else begin
            case (state)
                ST_CAPTURE: begin
                    if (fifo_wr) pkt_cnt  <= sat_inc16(pkt_cnt);
                    if (drop)    drop_cnt <= sat_inc8(drop_cnt);
                    if (timeframe_start_i) begin
                        state         <= ST_FLUSH;
                        start_pending <= 1'b1;
                    end else if (timeframe_end_i) begin
                        state <= ST_FLUSH;
                    end
                end
                ST_FLUSH: begin
                    if (timeframe_start_i) start_pending <= 1'b1;
                    if (flush_done)        state         <= ST_TRAILER;
                end
                ST_TRAILER: begin
                    if (timeframe_start_i) start_pending <= 1'b1;
                    if (dma_hs) begin
                        state  <= ST_IDLE;
                        busy_o <= 1'b0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Packet hold register: loaded from the FIFO head on each pop
    always_ff @(posedge sys_clk) begin
        if (fifo_rd) pkt_p1 <= fifo_rd_data;
    end

    // Serialiser control and DMA output register: two beats per packet, then trailer
    always_ff @(posedge sys_clk) begin
        if (!sys_reset_n) begin
            vld_p1      <= 1'b0;
            phase_p1    <= 1'b0;
            dma_valid_o <= 1'b0;
            dma_last_o  <= 1'b0;
            dma_data_o  <= '0;
        end else begin
            if (dma_hs) begin
                dma_valid_o <= 1'b0;
                dma_last_o  <= 1'b0;
            end
            // stage p1 -> output beat
            if (out_free && vld_p1) begin
                dma_valid_o <= 1'b1;
                dma_last_o  <= 1'b0;
                dma_data_o  <= phase_p1 ? pkt_p1[HALF-1:0] : pkt_p1[PKT_WIDTH-1:HALF];
                phase_p1    <= ~phase_p1;
                if (phase_p1) vld_p1 <= 1'b0;
            end
            // FIFO head -> stage p1
            if (fifo_rd) vld_p1 <= 1'b1;
            if (flush_done) begin
                dma_valid_o <= 1'b1;
                dma_last_o  <= 1'b1;
                dma_data_o  <= make_trailer(pkt_cnt, drop_cnt, frame_count_o);
            end
        end
    end

endmodule

// File: tb/tb_fofb_timeframe_capture.sv
// Directed scoreboard bench for fofb_timeframe_capture.
module tb_fofb_timeframe_capture;

    logic         sys_clk = 1'b0;
    logic         sys_reset_n;
    logic         timeframe_start_i;
    logic         timeframe_end_i;
    logic         pkt_valid_i;
    logic [127:0] pkt_data_i;
    logic         dma_ready_i;
    logic         dma_valid_o;
    logic [63:0]  dma_data_o;
    logic         dma_last_o;
    logic [31:0]  frame_count_o;
    logic         busy_o;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [64:0] exp_q[$];
    bit          toggle_en = 1'b0;
    bit          stall_prev = 1'b0;
    logic [64:0] stall_word;

    fofb_timeframe_capture #(
        .PKT_WIDTH   (128),
        .FIFO_AWIDTH (9)
    ) dut (
        .sys_clk           (sys_clk),
        .sys_reset_n       (sys_reset_n),
        .timeframe_start_i (timeframe_start_i),
        .timeframe_end_i   (timeframe_end_i),
        .pkt_valid_i       (pkt_valid_i),
        .pkt_data_i        (pkt_data_i),
        .dma_ready_i       (dma_ready_i),
        .dma_valid_o       (dma_valid_o),
        .dma_data_o        (dma_data_o),
        .dma_last_o        (dma_last_o),
        .frame_count_o     (frame_count_o),
        .busy_o            (busy_o)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic check(input string tag, input logic [65:0] obs, input logic [65:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Output monitor: stall stability and scoreboard compare on each handshake
    always @(negedge sys_clk) begin
        logic [64:0] e;
        if (stall_prev)
            check("stall_hold", {dma_valid_o, dma_last_o, dma_data_o}, {1'b1, stall_word});
        stall_prev = sys_reset_n && dma_valid_o && !dma_ready_i;
        stall_word = {dma_last_o, dma_data_o};
        if (sys_reset_n && dma_valid_o && dma_ready_i) begin
            check("beat_expected", 66'(exp_q.size() != 0), 66'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("beat", 66'({dma_last_o, dma_data_o}), 66'(e));
            end
        end
    end

    task automatic tick();
        @(posedge sys_clk);
        #1;
        if (toggle_en) dma_ready_i = ~dma_ready_i;
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    task automatic send_pkt(input logic [127:0] d, input bit expect_it);
        pkt_valid_i = 1'b1;
        pkt_data_i  = d;
        if (expect_it) begin
            exp_q.push_back({1'b0, d[127:64]});
            exp_q.push_back({1'b0, d[63:0]});
        end
        tick();
        pkt_valid_i = 1'b0;
    endtask

    task automatic pulse_start();
        timeframe_start_i = 1'b1;
        tick();
        timeframe_start_i = 1'b0;
    endtask

    task automatic pulse_end();
        timeframe_end_i = 1'b1;
        tick();
        timeframe_end_i = 1'b0;
    endtask

    task automatic push_trailer(input logic [15:0] cnt, input logic [7:0] drp, input logic [31:0] frm);
        exp_q.push_back({1'b1, 8'hA5, cnt, drp, frm});
    endtask

    task automatic wait_drain(input int budget, input string tag);
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < budget) begin
            tick();
            k++;
        end
        check(tag, 66'(exp_q.size()), 66'd0);
    endtask

    initial begin
        sys_reset_n       = 1'b0;
        timeframe_start_i = 1'b0;
        timeframe_end_i   = 1'b0;
        pkt_valid_i       = 1'b0;
        pkt_data_i        = '0;
        dma_ready_i       = 1'b1;
        ticks(3);
        check("rst_valid", 66'(dma_valid_o), 66'd0);
        check("rst_last",  66'(dma_last_o),  66'd0);
        check("rst_data",  66'(dma_data_o),  66'd0);
        check("rst_frame", 66'(frame_count_o), 66'd0);
        check("rst_busy",  66'(busy_o), 66'd0);
        sys_reset_n = 1'b1;
        ticks(2);

        // Basic frame with first-beat latency
        pulse_start();
        ticks(2);
        send_pkt({16{8'h11}}, 1'b1);
        @(negedge sys_clk);
        @(negedge sys_clk);
        check("lat_n1", 66'(dma_valid_o), 66'd0);
        @(negedge sys_clk);
        check("lat_n2", 66'(dma_valid_o), 66'd1);
        tick();
        send_pkt({16{8'h22}}, 1'b1);
        ticks(3);
        send_pkt({16{8'h33}}, 1'b1);
        ticks(7480);
        push_trailer(16'd3, 8'd0, 32'd1);
        pulse_end();
        wait_drain(100, "basic_drain");
        ticks(3);
        check("basic_busy", 66'(busy_o), 66'd0);
        check("basic_frame", 66'(frame_count_o), 66'd1);

        // Backpressure
        toggle_en = 1'b1;
        pulse_start();
        send_pkt({16{8'h11}}, 1'b1);
        ticks(2);
        send_pkt({16{8'h22}}, 1'b1);
        send_pkt({16{8'h33}}, 1'b1);
        ticks(20);
        push_trailer(16'd3, 8'd0, 32'd2);
        pulse_end();
        wait_drain(200, "bp_drain");
        toggle_en   = 1'b0;
        dma_ready_i = 1'b1;
        ticks(3);
        check("bp_busy", 66'(busy_o), 66'd0);

        // Overflow: 520 packets with the DMA stalled
        dma_ready_i = 1'b0;
        pulse_start();
        for (int i = 0; i < 520; i++)
            send_pkt({4{32'(i) ^ 32'hC0DE0000}}, i < 512);
        push_trailer(16'd512, 8'd8, 32'd3);
        pulse_end();
        ticks(5);
        dma_ready_i = 1'b1;
        wait_drain(3000, "ovf_drain");
        ticks(3);
        check("ovf_busy", 66'(busy_o), 66'd0);

        // Back-to-back frames: second start without an end
        pulse_start();
        tick();
        send_pkt({8{16'hBEEF}}, 1'b1);
        ticks(4);
        push_trailer(16'd1, 8'd0, 32'd4);
        pulse_start();
        send_pkt({8{16'hDEAD}}, 1'b0);
        wait_drain(100, "b2b_drain");
        ticks(3);
        check("b2b_frame", 66'(frame_count_o), 66'd5);
        check("b2b_busy",  66'(busy_o), 66'd1);
        push_trailer(16'd0, 8'd0, 32'd5);
        pulse_end();
        wait_drain(100, "b2b_drain2");
        ticks(3);
        check("b2b_idle", 66'(busy_o), 66'd0);

        // Boundary cycles: packet on start and on end cycle, others outside
        send_pkt({8{16'h0BAD}}, 1'b0);
        ticks(2);
        timeframe_start_i = 1'b1;
        send_pkt({4{32'hA0A0_0001}}, 1'b1);
        timeframe_start_i = 1'b0;
        ticks(3);
        timeframe_end_i = 1'b1;
        send_pkt({4{32'hB0B0_0002}}, 1'b1);
        timeframe_end_i = 1'b0;
        push_trailer(16'd2, 8'd0, 32'd6);
        send_pkt({4{32'hC0C0_0003}}, 1'b0);
        wait_drain(100, "bnd_drain");
        ticks(3);
        check("bnd_busy", 66'(busy_o), 66'd0);

        // Reset mid-frame during a stalled beat
        dma_ready_i = 1'b0;
        pulse_start();
        send_pkt({4{32'h5555_AAAA}}, 1'b1);
        ticks(6);
        sys_reset_n = 1'b0;
        tick();
        exp_q.delete();
        check("mrst_valid", 66'(dma_valid_o), 66'd0);
        check("mrst_last",  66'(dma_last_o),  66'd0);
        check("mrst_data",  66'(dma_data_o),  66'd0);
        check("mrst_frame", 66'(frame_count_o), 66'd0);
        check("mrst_busy",  66'(busy_o), 66'd0);
        sys_reset_n = 1'b1;
        dma_ready_i = 1'b1;
        ticks(20);
        check("mrst_empty", 66'(dma_valid_o), 66'd0);
        pulse_start();
        ticks(2);
        push_trailer(16'd0, 8'd0, 32'd1);
        pulse_end();
        wait_drain(100, "mrst_drain");
        ticks(3);
        check("mrst_idle", 66'(busy_o), 66'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
